otter_crypto_seq: RTL
=====================

Name: otter_crypto_seq

Overview:
Multi-cycle execution unit for OTTER custom ENCRY instructions (opcode 7'b1011011). ENCRY funct3 010 selects encrypt and 011 selects decrypt. The unit accepts an instruction from the decode/execute stage and stalls the core while it runs a parametrised number of rounds, one per cycle. It then presents the result for the register-file write path (RF_WR_SEL 4). It replaces the single-cycle crypto select, adding round iteration, a stall handshake, abort, and illegal-funct3 reporting.

Parameters:
WIDTH, 32, datapath width in bits (data, key, result).
ROUNDS, 8, number of cipher rounds, 1..255.
ROT, 5, per-round left-rotate amount; applied modulo WIDTH; 0 is legal.

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  asynchronous, active-high reset.
CRYPTO_VALID  in  1  instruction in execute is valid.
CRYPTO_OPCODE  in  7  instruction opcode.
CRYPTO_FUNC3  in  3  instruction funct3.
CRYPTO_FLUSH  in  1  abort in-flight operation (interrupt/branch flush).
DATA_IN  in  WIDTH  rs1 value (plaintext/ciphertext).
KEY_IN  in  WIDTH  rs2 value (key).
STALL  out  1  hold PC/pipeline.
BUSY  out  1  state is RUN.
RESULT  out  WIDTH  cipher result.
RESULT_VALID  out  1  one-cycle pulse; RESULT is valid for RF write.
ERR  out  1  one-cycle pulse; ENCRY with illegal funct3.

Behaviour:
- Reset, asynchronous: state goes to IDLE.
  - STALL, BUSY, RESULT_VALID and ERR go to 0.
  - RESULT, the data register, the key register, the mode and the round counter go to 0.
- Definition: a hit is CRYPTO_VALID && CRYPTO_OPCODE == 7'b1011011.
- The FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - On a hit with funct3 010 or 011 and CRYPTO_FLUSH == 0:
    - Latch DATA_IN, KEY_IN and the mode (010 = encrypt, 011 = decrypt).
    - Set the round counter to 0 for encrypt, or ROUNDS-1 for decrypt.
    - Go to RUN.
    - STALL = 1 combinationally in this acceptance cycle.
  - On a hit with any other funct3: ERR = 1 for this cycle, no state change, STALL = 0.
  - A non-hit is ignored.
- RUN:
  - Each cycle, one round i (i = counter) updates the data register.
  - Round key: k_i = rotl(key, i mod WIDTH).
  - Encrypt round: d <= rotl(d ^ k_i, ROT) + k_i.
  - Decrypt round: d <= rotr(d - k_i, ROT) ^ k_i.
  - All arithmetic is modulo 2^WIDTH.
  - Encrypt counts up and decrypt counts down. After exactly ROUNDS RUN cycles, go to DONE.
  - STALL = 1 and BUSY = 1 in every RUN cycle.
- DONE:
  - RESULT is loaded with the final data value on entry. RESULT_VALID = 1 and STALL = 0 for this one cycle.
  - Unconditionally go to IDLE; inputs are ignored, so the still-present instruction does not restart.
  - RESULT holds its value until the next DONE.
- Latency: the acceptance cycle is T0; RUN covers T1..T_ROUNDS; DONE is T_ROUNDS+1. STALL is high for T0..T_ROUNDS, which is ROUNDS+1 cycles.
- Invariant: decrypt(encrypt(x, k), k) == x for all x, k and all parameter values.
- CRYPTO_FLUSH:
  - In RUN: go to IDLE next cycle. No RESULT_VALID; RESULT is unchanged. STALL drops in the cycle after the flush.
  - In IDLE: it suppresses acceptance and ERR.
  - In DONE: ignored.
- Reset asserted mid-RUN aborts immediately. No RESULT_VALID follows.
- ROUNDS = 1: RUN lasts exactly one cycle.
- ROT = 0: rotation is the identity.
- ROT >= WIDTH: the amount is reduced modulo WIDTH.

Test Plan:
1. ROUNDS=1, ROT=0, encrypt, DATA_IN=0x00000001, KEY_IN=0x00000003 -> STALL high 2 cycles; RESULT_VALID 1 cycle at T2; RESULT=0x00000005. Decrypt of 0x00000005 with the same key -> 0x00000001.
2. ROUNDS=1, ROT=5, encrypt, data=0x00000001, key=0 -> RESULT=0x00000020.
3. ROUNDS=2, ROT=0, encrypt, data=0, key=1 -> RESULT=0x00000002. Decrypt 0x00000002 with key 1 -> 0x00000000.
4. Defaults, encrypt 0xDEADBEEF with key 0x12345678, then decrypt the result with the same key -> 0xDEADBEEF. Each operation: STALL high 9 cycles, RESULT_VALID at T9, BUSY high 8 cycles.
5. ENCRY with funct3=000 -> ERR pulse 1 cycle, STALL=0, no RESULT_VALID. Non-ENCRY opcode 0110011 with funct3=010 -> no response.
6. CRYPTO_FLUSH at T3 of a default encrypt -> IDLE at T4, no RESULT_VALID, RESULT unchanged. Separately, RST at T3 -> all outputs 0 immediately; a new operation afterwards completes correctly.

Source files
------------

// File: rtl/otter_crypto_seq_if.sv
// Handshake and data bundle between execute stage and crypto unit.
// Master drives the instruction side, slave returns stall/result.
interface otter_crypto_seq_if #(
    parameter int WIDTH = 32
);
    logic             CRYPTO_VALID;
    logic [6:0]       CRYPTO_OPCODE;
    logic [2:0]       CRYPTO_FUNC3;
    logic             CRYPTO_FLUSH;
    logic [WIDTH-1:0] DATA_IN;
    logic [WIDTH-1:0] KEY_IN;
    logic             STALL;
    logic             BUSY;
    logic [WIDTH-1:0] RESULT;
    logic             RESULT_VALID;
    logic             ERR;

    modport master (
        output CRYPTO_VALID, CRYPTO_OPCODE, CRYPTO_FUNC3,
        output CRYPTO_FLUSH, DATA_IN, KEY_IN,
        input  STALL, BUSY, RESULT, RESULT_VALID, ERR
    );

    modport slave (
        input  CRYPTO_VALID, CRYPTO_OPCODE, CRYPTO_FUNC3,
        input  CRYPTO_FLUSH, DATA_IN, KEY_IN,
        output STALL, BUSY, RESULT, RESULT_VALID, ERR
    );
endinterface

// File: rtl/otter_crypto_seq.sv
// Multi-cycle ENCRY execution unit: one cipher round per cycle,
// stalls the core while running, pulses RESULT_VALID when done.
module otter_crypto_seq #(
    parameter int WIDTH  = 32,
    parameter int ROUNDS = 8,
    parameter int ROT    = 5
) (
    input  logic CLK,
    input  logic RST,
    otter_crypto_seq_if.slave bus
);
    localparam int unsigned W = WIDTH;
    localparam logic [6:0] OP_ENCRY = 7'b1011011;
    localparam logic [2:0] F3_ENC = 3'b010;
    localparam logic [2:0] F3_DEC = 3'b011;
    localparam logic [7:0] LAST = 8'(ROUNDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] data_q, key_q, result_q;
    logic [WIDTH-1:0] rk, d_enc, d_dec, d_next;
    logic             dec_q;
    logic [7:0]       cnt_q;
    logic             hit, legal, accept, last;
    logic             stall_c, err_c;

    function automatic logic [WIDTH-1:0] rotl(
        input logic [WIDTH-1:0] x,
        input int unsigned      s
    );
        int unsigned a;
        a = s % W;
        if (a == 0) return x;
        return (x << a) | (x >> (W - a));
    endfunction

    function automatic logic [WIDTH-1:0] rotr(
        input logic [WIDTH-1:0] x,
        input int unsigned      s
    );
        int unsigned a;
        a = s % W;
        if (a == 0) return x;
        return (x >> a) | (x << (W - a));
    endfunction

    assign hit = bus.CRYPTO_VALID && (bus.CRYPTO_OPCODE == OP_ENCRY);
    assign legal = (bus.CRYPTO_FUNC3 == F3_ENC) ||
                   (bus.CRYPTO_FUNC3 == F3_DEC);
    assign accept = (state_q == IDLE) && hit && legal &&
                    !bus.CRYPTO_FLUSH;
    assign last = dec_q ? (cnt_q == 8'd0) : (cnt_q == LAST);

    // Round key and both round directions for the current counter.
    always_comb begin
        rk     = rotl(key_q, 32'(cnt_q));
        d_enc  = rotl(data_q ^ rk, 32'(ROT)) + rk;
        d_dec  = rotr(data_q - rk, 32'(ROT)) ^ rk;
        d_next = dec_q ? d_dec : d_enc;
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and combinational stall/error outputs.
    always_comb begin
        state_d = state_q;
        stall_c = 1'b0;
        err_c   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hit && !bus.CRYPTO_FLUSH) begin
                    if (legal) begin
                        state_d = RUN;
                        stall_c = 1'b1;
                    end else begin
                        err_c = 1'b1;
                    end
                end
            end
            RUN: begin
                stall_c = 1'b1;
                if (bus.CRYPTO_FLUSH) state_d = IDLE;
                else if (last)        state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand latch, round iteration and result capture.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data_q   <= '0;
            key_q    <= '0;
            dec_q    <= 1'b0;
            cnt_q    <= 8'd0;
            result_q <= '0;
        end else if (accept) begin
            data_q <= bus.DATA_IN;
            key_q  <= bus.KEY_IN;
            dec_q  <= bus.CRYPTO_FUNC3[0];
            cnt_q  <= bus.CRYPTO_FUNC3[0] ? LAST : 8'd0;
        end else if (state_q == RUN && !bus.CRYPTO_FLUSH) begin
            data_q <= d_next;
            cnt_q  <= dec_q ? cnt_q - 8'd1 : cnt_q + 8'd1;
            if (last) result_q <= d_next;
        end
    end

    // Reset forces the combinational outputs low as well.
    assign bus.STALL        = stall_c & ~RST;
    assign bus.ERR          = err_c & ~RST;
    assign bus.BUSY         = (state_q == RUN);
    assign bus.RESULT_VALID = (state_q == DONE);
    assign bus.RESULT       = result_q;

endmodule
